// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit per
// cycle, on operand magnitudes. The sign is corrected when the result is written.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module ex_muldiv_seq #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [REG_WIDTH-1:0] dataA,
  input  logic [REG_WIDTH-1:0] dataB,
  input  logic                 flush,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] result
);

  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]    opnd;     // multiplicand magnitude or divisor magnitude
  logic [2:0]      op_q;
  logic            neg_q;    // product / quotient must be negated
  logic            neg_r;    // remainder must be negated (dividend was negative)

  // Operand decode, used only in the cycle an op is accepted
  logic            a_signed, b_signed, a_neg, b_neg, is_div;
  logic            div_zero, div_ovf, fast;
  logic [W-1:0]    abs_a, abs_b, fast_val;

  // Per-iteration datapath and final sign correction
  logic [W:0]      add_sum;
  logic [W:0]      rem_shift;
  logic [W:0]      rem_diff;
  logic [2*W-1:0]  acc_next;
  logic [2*W-1:0]  prod_s;
  logic [W-1:0]    quo_s, rem_s, final_val;

  // Decode signedness, magnitudes and the single-cycle divide special cases
  always_comb begin
    is_div   = op[2];
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && dataA[W-1];
    b_neg    = b_signed && dataB[W-1];
    abs_a    = a_neg ? (~dataA + 1'b1) : dataA;
    abs_b    = b_neg ? (~dataB + 1'b1) : dataB;
    div_zero = is_div && (dataB == '0);
    // Most negative dividend over -1 overflows; only the signed divides (op[0]==0) care
    div_ovf  = is_div && !op[0] && (dataA == {1'b1, {(W-1){1'b0}}}) && (dataB == '1);
    fast     = div_zero || div_ovf;
    fast_val = '0;
    if (div_zero) begin
      fast_val = op[1] ? dataA : '1;
    end else if (div_ovf) begin
      fast_val = op[1] ? '0 : dataA;
    end
  end

  // One shift-add or restoring-subtract step, plus the sign-corrected final value
  always_comb begin
    add_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    rem_shift = {acc[2*W-1:W], acc[W-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
    if (op_q[2]) begin
      if (!rem_diff[W]) begin
        acc_next = {rem_diff[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[W-1:0], acc[W-2:0], 1'b0};
      end
    end else begin
      acc_next = acc[0] ? {add_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    end
    prod_s = neg_q ? (~acc_next + 1'b1) : acc_next;
    quo_s  = neg_q ? (~acc_next[W-1:0] + 1'b1) : acc_next[W-1:0];
    rem_s  = neg_r ? (~acc_next[2*W-1:W] + 1'b1) : acc_next[2*W-1:W];
    case (op_q)
      OP_MUL:                        final_val = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_val = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:               final_val = quo_s;
      default:                       final_val = rem_s;
    endcase
  end

  // Sequencer: accept, iterate, then present the result for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (fast) begin
              result <= fast_val;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              acc   <= is_div ? {{W{1'b0}}, abs_a} : {{W{1'b0}}, abs_b};
              opnd  <= is_div ? abs_b : abs_a;
              cnt   <= CW'(W);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              result <= final_val;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          // The owning instruction leaves EX at the end of this cycle
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is combinational so the accepting cycle already holds the pipeline
  always_comb begin
    stall = ((state == IDLE) && start && !flush) || (state == CALC);
    busy  = (state != IDLE);
  end

endmodule
